rv64_div_unit: RTL and testbench
================================

// Module: rv64_div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
//  Sits in EX beside the ALU. Its result feeds the 64-bit 2:1 writeback-select mux:
//  s=1 selects the divider result, s=0 selects the ALU result.
//  Uses a valid/ready handshake on both sides and holds off the pipeline while busy.
// PARAMETERS
//  XLEN     64                  operand/result width; only 64 is supported
//  CNT_W    $clog2(XLEN)+1      iteration counter width; derived, not overridable
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     request valid
//  in_ready   out  1     unit can accept; equals (state==IDLE)
//  op         in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  src1       in   XLEN  dividend
//  src2       in   XLEN  divisor
//  flush      in   1     abort in-flight op (branch redirect / trap)
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  quotient or remainder, per latched op
//  busy       out  1     state != IDLE; drives pipeline stall
// BEHAVIOUR
//  - Reset: state IDLE, out_valid 0, result 0, in_ready 1, busy 0, counter 0.
//  - Accept: in_valid && in_ready && !flush at edge T. Latch op, operand magnitudes, sign flags.
//  - FSM IDLE -> CALC -> DONE -> IDLE:
//    - IDLE->CALC on accept.
//    - CALC runs XLEN steps (T+1..T+64): shift {rem,quo} left 1; trial-subtract divisor;
//      set quo LSB if no borrow.
//    - CALC->DONE after the last step. out_valid=1 from T+65.
//    - DONE->IDLE when out_ready. No new accept in that same cycle (in_ready was 0).
//  - Special cases bypass CALC: IDLE->DONE directly, out_valid at T+1.
//    - Divisor zero: quotient all-ones, remainder = src1.
//    - Signed overflow (src1 = 0x8000_0000_0000_0000, src2 = all-ones, DIV/REM):
//      quotient = src1, remainder 0.
//  - Signed ops divide magnitudes.
//    - Quotient is negated iff the operand signs differ.
//    - Remainder takes the sign of the dividend. Negation is two's complement, XLEN bits.
//  - result and out_valid are registered, and are held stable while out_valid && !out_ready.
//  - flush (priority over everything except rst):
//    - Next state IDLE, out_valid 0, any pending result dropped.
//    - A request presented in the same cycle is not accepted.
//  - rst mid-operation: identical to reset values next cycle; no partial result escapes.
//  - in_ready is combinational from state only; it never depends on in_valid.
// CONFIGURATION
//  - Macro DIV_WORD_OP_EN adds input port `word` (1 bit) to enable DIVW/DIVUW/REMW/REMUW.
//  - Defined, word=1:
//    - Operands are src[31:0], sign- or zero-extended per op.
//    - 32 CALC steps; out_valid at T+33.
//    - result = sext(32-bit result).
//    - Divide by zero: quotient 0xFFFF_FFFF_FFFF_FFFF, remainder sext(src1[31:0]).
//    - Overflow -2^31 / -1: quotient 0xFFFF_FFFF_8000_0000, remainder 0.
//  - Undefined: no `word` port; all ops are 64-bit.
// STRUCTURE
//  - Package div_pkg:
//    - XLEN localparam.
//    - typedef enum div_op_e {DIV, DIVU, REM, REMU}.
//    - typedef enum div_state_e {IDLE, CALC, DONE}.
//    - function neg2c().
//  - One sub-module, div_step: combinational single restoring step
//    ({rem,quo}, divisor) -> ({rem',quo'}); instantiated once.
// TESTING
//  1. DIVU 100/7 accepted at T -> out_valid at T+65, result 14; REMU -> 2.
//  2. DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF.
//  3. DIVU 0x1234/0 -> all-ones at T+1; REMU -> 0x1234; CALC never entered.
//  4. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 at T+1; REM -> 0.
//  5. DIVU 100/7 with out_ready low 10 cycles after out_valid:
//     - result stays 14 and in_ready stays 0.
//     - After the handshake, the next request is accepted one cycle later.
//  6. Flush at T+20 of DIVU 100/7 -> in_ready 1 at T+21, out_valid never asserted.
//     A fresh DIVU 9/3 -> 3 at T+21+65.
//     With DIV_WORD_OP_EN: DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000 at T+1.

Source files
------------

// File: rtl/rv64_div_unit_pkg.sv
// div_pkg: shared types and helpers for the RV64M iterative divider.
//   XLEN         operand/result width (only 64 is supported)
//   CNT_W        iteration counter width, derived from XLEN
//   div_op_e     DIV / DIVU / REM / REMU encoding of the 2-bit op field
//   div_state_e  divider FSM states
//   neg2c()      two's complement negation, XLEN bits
//   sext32()     sign-extend the low 32 bits to XLEN
package div_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

endpackage

// File: rtl/rv64_div_unit_step.sv
// div_step: one combinational radix-2 restoring division step.
//   rem, quo     current partial remainder and quotient/dividend shift register
//   divisor      divisor magnitude
//   rem_nxt      partial remainder after the trial subtraction
//   quo_nxt      shift register with the new quotient bit in its LSB
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          borrow;

    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // Difference is always < divisor when there is no borrow, so the top
        // bit is set exactly when the subtraction went negative.
        borrow  = diff[XLEN];
        rem_nxt = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], ~borrow};
    end

endmodule

// File: rtl/rv64_div_unit.sv
// rv64_div_unit: iterative radix-2 restoring divider for RV64M
// DIV/DIVU/REM/REMU, sitting in EX beside the ALU.
//
// Optional feature macro: DIV_WORD_OP_EN adds the `word` input for
// DIVW/DIVUW/REMW/REMUW (32-bit operands, 32 steps, sign-extended result).
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   unit can accept (state == IDLE), combinational from state
//   op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   word       (DIV_WORD_OP_EN only) 32-bit word operation
//   src1       dividend
//   src2       divisor
//   flush      abort any in-flight or pending operation
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   result     quotient or remainder (registered, stable while stalled)
//   busy       state != IDLE, stalls the pipeline
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// && !flush; a result transfers on a rising edge where out_valid && out_ready.
// Once out_valid rises, result and out_valid hold until that transfer (or a
// flush/reset).
module rv64_div_unit
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
`ifdef DIV_WORD_OP_EN
    input  logic            word,
`endif
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  div_r;
    logic             rem_sel_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             word_r;

    logic             word_i;
`ifdef DIV_WORD_OP_EN
    assign word_i = word;
`else
    assign word_i = 1'b0;
`endif

    // ---------------- request decode ----------------
    logic            is_signed;
    logic [XLEN-1:0] a_ext, b_ext;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] min_val;
    logic            div_zero, ovf;
    logic [XLEN-1:0] spec_raw, spec_res;

    always_comb begin
        is_signed = ~op[0];
        // Word ops see sign/zero-extended low halves; the rest of the datapath
        // is then identical to the 64-bit case.
        if (word_i) begin
            a_ext   = is_signed ? sext32(src1[31:0]) : {32'b0, src1[31:0]};
            b_ext   = is_signed ? sext32(src2[31:0]) : {32'b0, src2[31:0]};
            min_val = 64'hFFFF_FFFF_8000_0000;
        end else begin
            a_ext   = src1;
            b_ext   = src2;
            min_val = 64'h8000_0000_0000_0000;
        end
        a_neg    = is_signed & a_ext[XLEN-1];
        b_neg    = is_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? neg2c(a_ext) : a_ext;
        b_mag    = b_neg ? neg2c(b_ext) : b_ext;
        div_zero = (b_ext == '0);
        ovf      = is_signed && (a_ext == min_val) && (&b_ext);
        // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
        if (div_zero)
            spec_raw = op[1] ? a_ext : '1;
        else
            spec_raw = op[1] ? '0 : a_ext;
        spec_res = word_i ? sext32(spec_raw[31:0]) : spec_raw;
    end

    // ---------------- iteration ----------------
    logic [XLEN-1:0] rem_nxt, quo_nxt;

    div_step u_step (
        .rem     (rem_r),
        .quo     (quo_r),
        .divisor (div_r),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Sign fix-up of the final step, computed combinationally so the result
    // register loads on the same edge as the last step.
    logic [XLEN-1:0] q_fix, r_fix, calc_raw, calc_res;

    always_comb begin
        q_fix    = neg_q_r ? neg2c(quo_nxt) : quo_nxt;
        r_fix    = neg_r_r ? neg2c(rem_nxt) : rem_nxt;
        calc_raw = rem_sel_r ? r_fix : q_fix;
        calc_res = word_r ? sext32(calc_raw[31:0]) : calc_raw;
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            div_r     <= '0;
            rem_sel_r <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            word_r    <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem_sel_r <= op[1];
                        neg_q_r   <= a_neg ^ b_neg;
                        neg_r_r   <= a_neg;
                        word_r    <= word_i;
                        div_r     <= b_mag;
                        rem_r     <= '0;
                        // Word dividends start in the top half so that 32 steps
                        // leave the quotient in the low half.
                        quo_r     <= word_i ? {a_mag[31:0], 32'b0} : a_mag;
                        if (div_zero || ovf) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= spec_res;
                            cnt       <= '0;
                        end else begin
                            state <= CALC;
                            cnt   <= word_i ? CNT_W'(32) : CNT_W'(XLEN);
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= calc_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv64_div_unit.sv
// tb_rv64_div_unit: self-checking bench for rv64_div_unit with a behavioural
// division model (plain SystemVerilog / and %), a per-cycle compare process,
// directed literal cases and a randomized phase.
module tb_rv64_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic        word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    rv64_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
`ifdef DIV_WORD_OP_EN
        .word      (word),
`endif
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    bit rdy_rand = 1'b0;
    bit flush_rand = 1'b0;
    int ready_cyc = 0;
    logic [63:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ext(logic [63:0] x, logic w, logic sgn);
        if (!w) return x;
        return sgn ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]};
    endfunction

    function automatic logic [63:0] ref_div(logic [1:0] o, logic [63:0] a, logic [63:0] b, logic w);
        logic        sgn;
        logic [63:0] ae, be, q, r, res;
        logic signed [63:0] sa, sb;
        sgn = (o == DIV) || (o == REM);
        ae  = ext(a, w, sgn);
        be  = ext(b, w, sgn);
        if (be == 0) begin
            q = '1;
            r = ae;
        end else if (!w && sgn && ae == 64'h8000_0000_0000_0000 && be == '1) begin
            q = ae;
            r = '0;
        end else if (sgn) begin
            sa = ae;
            sb = be;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = ae / be;
            r = ae % be;
        end
        res = (o == REM || o == REMU) ? r : q;
        return w ? {{32{res[31]}}, res[31:0]} : res;
    endfunction

    // Edges from accept to out_valid visible.
    function automatic int ref_lat(logic [1:0] o, logic [63:0] a, logic [63:0] b, logic w);
        logic        sgn;
        logic [63:0] ae, be;
        sgn = (o == DIV) || (o == REM);
        ae  = ext(a, w, sgn);
        be  = ext(b, w, sgn);
        if (be == 0) return 0;
        if (sgn && be == '1 && ae == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 0;
        return w ? 32 : 64;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : mon
        bit ov_exp;
        ov_exp = (exp_q.size() != 0) && (cyc >= ready_cyc);
        if (mon_en) begin
            chk("in_ready", {63'b0, in_ready}, {63'b0, exp_q.size() == 0});
            chk("busy", {63'b0, busy}, {63'b0, exp_q.size() != 0});
            chk("out_valid", {63'b0, out_valid}, {63'b0, ov_exp});
            if (ov_exp) chk("result", result, exp_q[0]);
        end
        if (rst) begin
            exp_q.delete();
            mon_en = 1'b1;
        end else if (flush) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (ov_exp && out_ready) void'(exp_q.pop_front());
        end else if (in_valid) begin
            exp_q.push_back(ref_div(op, src1, src2, word));
            ready_cyc = cyc + 1 + ref_lat(op, src1, src2, word);
        end
    end

    // Random consumer back-pressure and occasional flush.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 1) == 1);
        if (flush_rand) flush = ($urandom_range(0, 511) == 0);
    end

    // ---------------- driver tasks ----------------
    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(logic [1:0] o, logic [63:0] a, logic [63:0] b, logic w);
        int n = 0;
        while (!in_ready && n < 400) begin
            step();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout cyc=%0d got in_ready=0 want 1", cyc);
            return;
        end
        op = o;
        src1 = a;
        src2 = b;
        word = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        src1 = {$urandom, $urandom};
        src2 = {$urandom, $urandom};
    endtask

    task automatic run_lit(string name, logic [1:0] o, logic [63:0] a, logic [63:0] b, logic w,
                           logic [63:0] expv, int exp_lat, int hold);
        int n = 0;
        out_ready = 1'b0;
        issue(o, a, b, w);
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        chk(name, result, expv);
        if (hold > 0) begin
            step(hold);
            chk({name, "_hold_res"}, result, expv);
            chk({name, "_hold_rdy"}, {63'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_next_rdy"}, {63'b0, in_ready}, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] a, b;
        logic [1:0]  o;
        logic        w;
        int          n;

        // Model pins.
        chk("pin_divu", ref_div(DIVU, 64'd100, 64'd7, 1'b0), 64'd14);
        chk("pin_remu", ref_div(REMU, 64'd100, 64'd7, 1'b0), 64'd2);
        chk("pin_div_neg", ref_div(DIV, -64'sd7, 64'd2, 1'b0), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("pin_rem_neg", ref_div(REM, -64'sd7, 64'd2, 1'b0), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pin_div0", ref_div(DIVU, 64'h1234, 64'd0, 1'b0), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pin_ovf", ref_div(DIV, 64'h8000_0000_0000_0000, '1, 1'b0), 64'h8000_0000_0000_0000);
        chk("pin_w_ovf", ref_div(DIV, 64'h8000_0000, '1, 1'b1), 64'hFFFF_FFFF_8000_0000);

        // Reset.
        step(3);
        rst = 1'b0;
        chk("rst_result", result, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);

        // Directed cases.
        run_lit("divu_100_7", DIVU, 64'd100, 64'd7, 1'b0, 64'd14, 64, 0);
        run_lit("remu_100_7", REMU, 64'd100, 64'd7, 1'b0, 64'd2, 64, 0);
        run_lit("div_m7_2", DIV, -64'sd7, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
        run_lit("rem_m7_2", REM, -64'sd7, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 0);
        run_lit("divu_by0", DIVU, 64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        run_lit("remu_by0", REMU, 64'h1234, 64'd0, 1'b0, 64'h1234, 0, 0);
        run_lit("div_ovf", DIV, 64'h8000_0000_0000_0000, '1, 1'b0, 64'h8000_0000_0000_0000, 0, 0);
        run_lit("rem_ovf", REM, 64'h8000_0000_0000_0000, '1, 1'b0, 64'd0, 0, 0);
        run_lit("divu_stall", DIVU, 64'd100, 64'd7, 1'b0, 64'd14, 64, 10);
        run_lit("divu_9_3_b2b", DIVU, 64'd9, 64'd3, 1'b0, 64'd3, 64, 0);

        // Flush mid-calculation, then a fresh request.
        issue(DIVU, 64'd100, 64'd7, 1'b0);
        step(19);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        run_lit("after_flush", DIVU, 64'd9, 64'd3, 1'b0, 64'd3, 64, 0);

        // Flush together with a request in IDLE: not accepted.
        op = DIVU; src1 = 64'd50; src2 = 64'd5; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_req_busy", {63'b0, busy}, 64'd0);

        // Flush a pending (stalled) result.
        issue(DIVU, 64'd5, 64'd0, 1'b0);
        step(3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_done_ov", {63'b0, out_valid}, 64'd0);

        // Reset mid-operation.
        issue(DIV, 64'd12345, 64'd17, 1'b0);
        step(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_result", result, 64'd0);
        chk("midrst_ov", {63'b0, out_valid}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);

`ifdef DIV_WORD_OP_EN
        run_lit("divw_ovf", DIV, 64'h8000_0000, '1, 1'b1, 64'hFFFF_FFFF_8000_0000, 0, 0);
        run_lit("divuw_100_7", DIVU, 64'hABCD_0000_0000_0064, 64'd7, 1'b1, 64'd14, 32, 0);
        run_lit("remw_by0", REM, 64'h0000_0000_8000_0001, 64'h1_0000_0000, 1'b1,
                64'hFFFF_FFFF_8000_0001, 0, 0);
`endif

        // Randomized phase.
        rdy_rand = 1'b1;
        flush_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = 64'h8000_0000_0000_0000; b = '1; end
                2: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 40)); end
                3: b = 64'($urandom_range(1, 255));
                4: begin a = -64'($urandom_range(0, 5000)); b = -64'($urandom_range(1, 50)); end
                default: ;
            endcase
`ifdef DIV_WORD_OP_EN
            w = ($urandom_range(0, 2) == 0);
            if (w && $urandom_range(0, 7) == 0) begin a = 64'h8000_0000; b = '1; end
`else
            w = 1'b0;
`endif
            issue(o, a, b, w);
        end

        // Drain.
        rdy_rand = 1'b0;
        flush_rand = 1'b0;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        chk("drain_busy", {63'b0, busy}, 64'd0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
